// File: rtl/eeprom_ctrl.sv
// Timed EEPROM word array with a command/ready handshake: read, word erase,
// word program (bit-clear only), chip erase, write protect and error pulses.
module eeprom_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int ERASE_CYCLES = 4,
    parameter int PROG_CYCLES  = 3,
    parameter int CHIP_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wp,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int MAXC  = (ERASE_CYCLES > PROG_CYCLES)
                         ? ((ERASE_CYCLES > CHIP_CYCLES) ? ERASE_CYCLES : CHIP_CYCLES)
                         : ((PROG_CYCLES > CHIP_CYCLES) ? PROG_CYCLES : CHIP_CYCLES);
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, READ, BUSY, DONE} state_t;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_ERASE = 2'b01,
        OP_PROG  = 2'b10,
        OP_CHIP  = 2'b11
    } op_t;

    // Words are stored inverted so the zero power-up state reads back as erased.
    logic [DATA_W-1:0] mem_n [DEPTH];

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] word;
    logic              commit;
    op_t               op_in;

    assign op_in  = op_t'(cmd_op);
    assign word   = ~mem_n[addr_q];
    assign commit = (state == BUSY) && (cnt == '0);

    function automatic logic [CNT_W-1:0] busy_len(input op_t op);
        case (op)
            OP_ERASE: busy_len = CNT_W'(ERASE_CYCLES - 1);
            OP_PROG:  busy_len = CNT_W'(PROG_CYCLES - 1);
            default:  busy_len = CNT_W'(CHIP_CYCLES - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            data_q    <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_valid  <= 1'b0;
            data_out  <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_in;
                        addr_q    <= addr;
                        data_q    <= data_in;
                        cmd_ready <= 1'b0;
                        if (op_in == OP_READ) begin
                            state <= READ;
                        end else if (wp) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            cnt   <= busy_len(op_in);
                        end
                    end
                end
                READ: begin
                    data_out  <= word;
                    rd_valid  <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= (op_q == OP_PROG) && ((word & data_q) != data_q);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is deliberately outside the reset domain; an abort simply never commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            case (op_q)
                OP_ERASE: mem_n[addr_q] <= '0;
                OP_PROG:  mem_n[addr_q] <= mem_n[addr_q] | ~data_q;
                OP_CHIP: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        mem_n[ADDR_W'(i)] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
